// File: rtl/sr_cmd_if.sv
// Interface carrying the raw button inputs and the registered SR command.
// The generator connects through the master modport; the consumer uses the slave modport.
interface sr_cmd_if;
  logic       set_btn;
  logic       rst_btn;
  logic [1:0] sr;
  logic       sr_valid;
  logic       set_pend;

  modport master (input set_btn, input rst_btn, output sr, output sr_valid, output set_pend);
  modport slave  (output set_btn, output rst_btn, input sr, input sr_valid, input set_pend);
endinterface

// File: rtl/sr_cmd_gen.sv
// Synchronizes and debounces the set and reset buttons, then turns the rising edges into one-cycle SR commands.
// A reset command always wins; a set that collides with a reset is deferred for one cycle.
module sr_cmd_gen #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic    clk,
  input  logic    rst,
  sr_cmd_if.master bus
);

  localparam int unsigned CW = $clog2(DB_CYCLES) + 1;
  localparam int RST_CH = 0;
  localparam int SET_CH = 1;

  typedef enum logic [1:0] {
    CMD_HOLD  = 2'b00,
    CMD_RESET = 2'b01,
    CMD_SET   = 2'b10
  } cmd_e;

  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_prev;
  logic [1:0]    rise;
  logic [CW-1:0] cnt [2];
  cmd_e          sr_q;
  logic          sr_valid_q;
  logic          set_pend_q;

  assign raw  = {bus.set_btn, bus.rst_btn};
  assign rise = db & ~db_prev;

  always_ff @(posedge clk) begin
    // NOTE: every register here uses non-blocking assignment so all state samples pre-edge values.
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      db         <= '0;
      db_prev    <= '0;
      // NOTE: the counter array is small control state, not storage, so it is reset like any flop.
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
      sr_q       <= CMD_HOLD;
      sr_valid_q <= 1'b0;
      set_pend_q <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db;

      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end

      // Reset wins; a colliding set is parked in set_pend and issued once no reset is asked for.
      if (rise[RST_CH]) begin
        sr_q       <= CMD_RESET;
        sr_valid_q <= 1'b1;
        set_pend_q <= set_pend_q | rise[SET_CH];
      end else if (rise[SET_CH] || set_pend_q) begin
        sr_q       <= CMD_SET;
        sr_valid_q <= 1'b1;
        set_pend_q <= 1'b0;
      end else begin
        sr_q       <= CMD_HOLD;
        sr_valid_q <= 1'b0;
      end
    end
  end

  assign bus.sr       = sr_q;
  assign bus.sr_valid = sr_valid_q;
  assign bus.set_pend = set_pend_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed and random bench for sr_cmd_gen; expected commands are queued at stimulus time
// with their due edge and compared when that edge's outputs are sampled.
module tb_sr_cmd_gen;
  localparam int DB = 4;

  typedef struct {
    int unsigned at_edge;
    logic [1:0]  sr;
    logic        pend;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned edge_no = 0;
  int unsigned n_assert = 0;
  int unsigned n_fail = 0;
  exp_t        sb[$];

  sr_cmd_if bus ();

  sr_cmd_gen #(.DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic void push(input int unsigned at, input logic [1:0] sr, input logic pend);
    exp_t e;
    e.at_edge = at;
    e.sr      = sr;
    e.pend    = pend;
    sb.push_back(e);
  endfunction

  // Drive inputs for the next rising edge, then sample outputs on the following falling edge.
  task automatic step(input logic s, input logic r, input logic rs, input bit exact);
    logic [1:0] exp_sr;
    logic       exp_pend;
    exp_t       e;
    bus.set_btn = s;
    bus.rst_btn = r;
    rst         = rs;
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    n_assert++;
    assert (bus.sr !== 2'b11)
      else begin n_fail++; $error("FAIL sr_not_11 edge %0d: got %b expected not 11", edge_no, bus.sr); end
    if (exact) begin
      exp_sr   = 2'b00;
      exp_pend = 1'b0;
      if (sb.size() > 0 && sb[0].at_edge == edge_no) begin
        e        = sb.pop_front();
        exp_sr   = e.sr;
        exp_pend = e.pend;
      end
      n_assert++;
      assert (bus.sr === exp_sr)
        else begin n_fail++; $error("FAIL sr edge %0d: got %b expected %b", edge_no, bus.sr, exp_sr); end
      n_assert++;
      assert (bus.sr_valid === (exp_sr != 2'b00))
        else begin n_fail++; $error("FAIL sr_valid edge %0d: got %b expected %b", edge_no, bus.sr_valid, exp_sr != 2'b00); end
      n_assert++;
      assert (bus.set_pend === exp_pend)
        else begin n_fail++; $error("FAIL set_pend edge %0d: got %b expected %b", edge_no, bus.set_pend, exp_pend); end
    end else begin
      n_assert++;
      assert (bus.sr_valid === (bus.sr != 2'b00))
        else begin n_fail++; $error("FAIL sr_valid_or edge %0d: got %b expected %b", edge_no, bus.sr_valid, bus.sr != 2'b00); end
    end
  endtask

  initial begin
    int unsigned k;
    logic s;
    logic r;
    bus.set_btn = 1'b0;
    bus.rst_btn = 1'b0;
    @(negedge clk);

    // Reset state: two reset cycles, then idle.
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Clean set press: one sr=10 at DB+2 edges after first sampling; release issues nothing.
    k = edge_no + 1;
    push(k + DB + 2, 2'b10, 1'b0);
    repeat (DB + 6) step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (DB + 4) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset button pulse shorter than DB: no command.
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (DB + 6) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Simultaneous press: reset first with set pending, then the deferred set.
    k = edge_no + 1;
    push(k + DB + 2, 2'b01, 1'b1);
    push(k + DB + 3, 2'b10, 1'b0);
    repeat (DB + 6) step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (DB + 4) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Bouncing set: 1,0,1,0 then held; timed from the start of the stable level.
    k = edge_no + 1;
    push(k + 4 + DB + 2, 2'b10, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (DB + 6) step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (DB + 4) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset on the edge where the debounce would accept: nothing issued, then a fresh edge after release.
    repeat (DB + 1) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    k = edge_no + 1;
    push(k + DB + 2, 2'b10, 1'b0);
    repeat (DB + 6) step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (DB + 4) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random bouncing on both buttons: encoding invariants only.
    s = 1'b0;
    r = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) s = ~s;
      if ($urandom_range(0, 7) == 0) r = ~r;
      step(s, r, 1'b0, 1'b0);
    end

    // Reset must clear everything regardless of prior state.
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1);

    n_assert++;
    assert (sb.size() == 0)
      else begin n_fail++; $error("FAIL scoreboard_drained: got %0d entries expected 0", sb.size()); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4, number of consecutive stable cycles a synchronized input must hold before it is accepted (legal 2..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 set_btn  input  1  raw asynchronous set request (active-high, may bounce).
REQ-005 rst_btn  input  1  raw asynchronous reset request (active-high, may bounce).
REQ-006 sr  output  2  registered command to the downstream SR flip-flop: 00 hold, 01 reset, 10 set; 11 never driven.
REQ-007 sr_valid  output  1  registered, high exactly when sr != 00.
REQ-008 set_pend  output  1  registered, high while a set command is deferred by arbitration.

Function
REQ-009 Each raw input SHALL pass through its own two-flop synchronizer before any other use.
REQ-010 Each channel SHALL hold a debounced level db (reset 0) and a counter cnt (width ceil(log2(DB_CYCLES))+1, reset 0).
REQ-011 If synchronized level equals db, cnt SHALL clear to 0 that cycle.
REQ-012 If synchronized level differs from db, cnt SHALL increment; on the DB_CYCLES-th consecutive mismatch db SHALL take the synchronized level and cnt SHALL clear.
REQ-013 A glitch shorter than DB_CYCLES synchronized cycles SHALL produce no db change and no command.
REQ-014 A rising edge of a channel's db (db high, previous-cycle db low) SHALL create one request; falling edges SHALL create nothing.
REQ-015 Latency: a clean raw rising level sampled at edge N SHALL drive sr for exactly one cycle, registered at edge N+DB_CYCLES+2.
REQ-016 Reset request alone: sr=01 for one cycle; set request alone: sr=10 for one cycle; otherwise sr=00.
REQ-017 Simultaneous set and reset requests: sr=01 that cycle, set_pend SHALL set; the deferred set SHALL issue as sr=10 the following cycle and set_pend SHALL clear with it.
REQ-018 With set_pend high and a new reset request: sr=01, set_pend stays high (reset always wins).
REQ-019 With set_pend high and a new set request (no reset): single sr=10, set_pend clears; the two set requests SHALL merge.
REQ-020 sr SHALL never equal 11 in any cycle, including during and after reset.
REQ-021 sr_valid SHALL equal the OR of both sr bits registered in the same cycle, never lagging sr.

Reset
REQ-022 With rst high at a clock edge: synchronizers, db, previous-db, cnt, sr, sr_valid and set_pend SHALL all become 0 at that edge.
REQ-023 rst SHALL take priority over every other event in the same cycle, discarding in-progress debounce counts and pending sets.
REQ-024 A button held high across reset release SHALL be treated as a new edge: it issues its command DB_CYCLES+2 edges after the first non-reset sampling edge.
REQ-025 No command SHALL be issued while rst is high.

Verification
REQ-026 DB_CYCLES=4, rst 1 for 2 cycles then 0; set_btn 0->1 held -> sr=10, sr_valid=1 for exactly one cycle, 6 edges after first sampling, then sr=00.
REQ-027 rst_btn pulsed high for 3 cycles only -> sr stays 00, db for reset channel stays 0, no sr_valid.
REQ-028 set_btn and rst_btn rise in same cycle, held -> sr=01 with set_pend=1, next cycle sr=10 with set_pend=0, then 00.
REQ-029 set_btn bounces 1,0,1,0 each cycle then holds 1 -> exactly one sr=10, timed from the start of the stable level.
REQ-030 rst asserted one cycle before sr would assert (debounce count at 3) -> sr stays 00, counters cleared; with set_btn still high, sr=10 appears DB_CYCLES+2 edges after rst release.
REQ-031 Random bounce stimulus on both buttons for 10,000 cycles -> sr never 11, sr_valid always equals |sr.
